// File: rtl/rv_mem_pkg.sv
// Shared types for the data-memory load path: funct3 load codes, load FSM states,
// word width and the misalignment predicate used when LOAD_MISALIGN_TRAP_EN is defined.
package rv_mem_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    LSEL_LB  = 3'b000,
    LSEL_LH  = 3'b001,
    LSEL_LW  = 3'b010,
    LSEL_LBU = 3'b100,
    LSEL_LHU = 3'b101
  } lsel_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } load_state_t;

  // True for loads that must trap: odd halfword, unaligned word, or an unused funct3.
  function automatic logic load_misaligned(input logic [2:0] lsel, input logic [1:0] off);
    logic bad;
    bad = 1'b1;
    case (lsel)
      LSEL_LB, LSEL_LBU: bad = 1'b0;
      LSEL_LH, LSEL_LHU: bad = off[0];
      LSEL_LW:           bad = (off != 2'b00);
      default:           bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational lane select and sign/zero extension of a little-endian memory word.
// Unused funct3 codes fall through to the full-word path.
module load_align
  import rv_mem_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      off,
  input  logic [2:0]      lsel,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_lane [4];
  logic [15:0] half_lane [2];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign byte_lane[gi] = rdata[8*gi +: 8];
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_half
    assign half_lane[gi] = rdata[16*gi +: 16];
  end

  // Halfwords only look at off[1]; off[0] is either trapped upstream or ignored.
  assign sel_byte = byte_lane[off];
  assign sel_half = half_lane[off[1]];

  always_comb begin
    data = rdata;
    case (lsel)
      LSEL_LB:  data = {{24{sel_byte[7]}}, sel_byte};
      LSEL_LBU: data = {24'd0, sel_byte};
      LSEL_LH:  data = {{16{sel_half[15]}}, sel_half};
      LSEL_LHU: data = {16'd0, sel_half};
      default:  data = rdata;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Single-outstanding load unit: IDLE -> ISSUE (one read strobe) -> WAIT -> RESP.
// Define LOAD_MISALIGN_TRAP_EN to trap misaligned/illegal loads straight to RESP with rsp_err=1.
module load_unit
  import rv_mem_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic [2:0]      req_lsel,
  output logic            mem_re,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_err
);

  load_state_t     state_reg, state_next;
  logic [XLEN-3:0] addr_hi_reg;
  logic [1:0]      off_reg;
  logic [2:0]      lsel_reg;
  logic [XLEN-1:0] rsp_data_reg;
  logic [XLEN-1:0] aligned_data;
  logic            accept;
  logic            trap;
  logic            capture;

`ifdef LOAD_MISALIGN_TRAP_EN
  assign trap = load_misaligned(req_lsel, req_addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  assign accept  = (state_reg == ST_IDLE) && req_valid;
  assign capture = (state_reg == ST_WAIT) && mem_rvalid;

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    mem_re     = 1'b0;
    rsp_valid  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = trap ? ST_RESP : ST_ISSUE;
      end
      ST_ISSUE: begin
        mem_re     = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_rvalid) state_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // A trapped request never reaches ISSUE, so mem_addr keeps the previous read address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_hi_reg  <= '0;
      off_reg      <= '0;
      lsel_reg     <= '0;
      rsp_data_reg <= '0;
    end else begin
      if (accept) begin
        off_reg  <= req_addr[1:0];
        lsel_reg <= req_lsel;
        if (!trap) addr_hi_reg <= req_addr[XLEN-1:2];
        else       rsp_data_reg <= '0;
      end
      if (capture) rsp_data_reg <= aligned_data;
    end
  end

  load_align u_align (
    .rdata (mem_rdata),
    .off   (off_reg),
    .lsel  (lsel_reg),
    .data  (aligned_data)
  );

  assign mem_addr = {addr_hi_reg, 2'b00};
  assign rsp_data = rsp_data_reg;

`ifdef LOAD_MISALIGN_TRAP_EN
  logic rsp_err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_err_reg <= 1'b0;
    end else begin
      if (accept)  rsp_err_reg <= trap;
      if (capture) rsp_err_reg <= 1'b0;
    end
  end

  assign rsp_err = rsp_err_reg;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: doc/load_unit.md
LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 The block SHALL expose: clk  input  1  rising-edge clock.
REQ-002 The block SHALL expose: rst  input  1  reset, asynchronous, active-high.
REQ-003 The block SHALL expose: req_valid  input  1  load request present.
REQ-004 The block SHALL expose: req_ready  output  1  block can accept a request.
REQ-005 The block SHALL expose: req_addr  input  32  byte address.
REQ-006 The block SHALL expose: req_lsel  input  3  load type (funct3): LB=000, LH=001, LW=010, LBU=100, LHU=101.
REQ-007 The block SHALL expose: mem_re  output  1  one-cycle data-memory read strobe.
REQ-008 The block SHALL expose: mem_addr  output  32  word-aligned read address, {addr[31:2],2'b00}.
REQ-009 The block SHALL expose: mem_rvalid  input  1  read data valid.
REQ-010 The block SHALL expose: mem_rdata  input  32  raw little-endian memory word.
REQ-011 The block SHALL expose: rsp_valid  output  1  load result valid.
REQ-012 The block SHALL expose: rsp_ready  input  1  consumer accepts result.
REQ-013 The block SHALL expose: rsp_data  output  32  aligned, extended load result.
REQ-014 The block SHALL expose: rsp_err  output  1  misaligned or illegal load.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP; req_ready=1 only in IDLE.
REQ-016 In IDLE, on req_valid, the block SHALL register addr[31:2], addr[1:0] and lsel, then go to ISSUE.
REQ-017 ISSUE SHALL drive mem_re=1 for exactly one cycle with the registered mem_addr, then go to WAIT.
REQ-018 WAIT SHALL hold until mem_rvalid=1; it SHALL then capture the extracted result and go to RESP. mem_rvalid outside WAIT SHALL be ignored.
REQ-019 RESP SHALL hold rsp_valid=1 and stable rsp_data/rsp_err until rsp_ready=1, then return to IDLE; no new request is accepted in that same cycle.
REQ-020 Minimum latency SHALL be: accept at cycle N, mem_re at N+1, mem_rvalid at N+2, rsp_valid at N+3.
REQ-021 Extraction SHALL be: byte = rdata[8*off+7:8*off]; half = rdata[16*off[1]+15:16*off[1]]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes rdata unchanged.
REQ-022 mem_addr SHALL hold its last value outside ISSUE; mem_re SHALL be 0 outside ISSUE.

Reset
REQ-023 rst SHALL force IDLE immediately, with rsp_valid=0, rsp_data=0, rsp_err=0, mem_re=0 and mem_addr=0.
REQ-024 A reset during ISSUE, WAIT or RESP SHALL abandon the load; a late mem_rvalid after reset SHALL produce no response.

Configuration
REQ-025 With LOAD_MISALIGN_TRAP_EN defined, LH/LHU with addr[0]=1, LW with addr[1:0]!=0, or an lsel of 011, 110 or 111 SHALL skip the memory read, going IDLE->RESP with rsp_err=1 and rsp_data=0.
REQ-026 Without LOAD_MISALIGN_TRAP_EN, rsp_err SHALL be tied 0.
REQ-027 Without LOAD_MISALIGN_TRAP_EN, LH/LHU SHALL use only addr[1], LW SHALL ignore addr[1:0], and illegal lsel values SHALL be treated as LW.

Structure
REQ-028 Package rv_mem_pkg SHALL hold the lsel_t enum (funct3 codes), the FSM state enum and a word-width constant (32).
REQ-029 Extraction/extension SHALL be a combinational sub-module, load_align (inputs rdata, off, lsel; output data), instantiated once.

Verification
REQ-030 LB at addr 0x103 with rdata 0x80FF1234 (rvalid at N+2) -> rsp_data 0xFFFFFF80 at N+3, rsp_err=0.
REQ-031 LHU at addr 0x102 with rdata 0x80FF1234 -> rsp_data 0x000080FF; LH at the same address -> 0xFFFF80FF; mem_addr=0x100 in both cases.
REQ-032 LW at 0x200, rvalid delayed 5 cycles after mem_re, rsp_ready held low 3 cycles -> rsp_data 0xDEADBEEF stable throughout, a single mem_re pulse, and req_ready=0 until the handshake completes.
REQ-033 LW at 0x201: with the macro -> rsp_err=1, rsp_data=0, no mem_re. Without the macro -> a read at 0x200 and the full word is returned.
REQ-034 rst asserted in WAIT, then mem_rvalid=1 -> immediately IDLE, all outputs 0, no rsp_valid; the next LBU at 0x0 with rdata 0x000000AB returns 0x000000AB.
